uart_rx_os: RTL and testbench
=============================

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVS, default 16, baud_tick pulses per bit, even, legal 8..32.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO words, power of 2, legal 2..16.
REQ-006 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-007 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port baud_tick  input  1  single-cycle oversample strobe, OVS per bit period.
REQ-009 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data  output  DATA_W  FIFO head data word.
REQ-011 SHALL have port rx_perr  output  1  FIFO head parity-error flag.
REQ-012 SHALL have port rx_ferr  output  1  FIFO head framing-error flag.
REQ-013 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-014 SHALL have port rx_ready  input  1  consumer accept; pop when rx_valid and rx_ready are both high.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-018 SHALL count baud_tick only; states advance only on cycles where baud_tick is high.
REQ-019 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-020 SHALL go from IDLE to START on a falling edge of the synchronized rx.
REQ-021 SHALL, in START, sample after OVS/2 ticks: low goes to DATA, high (glitch) returns to IDLE with nothing pushed.
REQ-022 SHALL sample each later bit OVS ticks after the previous sample (bit centre).
REQ-023 SHALL shift DATA_W data bits in LSB first.
REQ-024 SHALL enter PARITY after the last data bit when PARITY is not 0, otherwise go straight to STOP.
REQ-025 SHALL set the parity error when the XOR of the data bits and the parity bit is 0 for odd mode, or 1 for even mode.
REQ-026 SHALL, in STOP, sample STOP_BITS stop bits; any low stop bit sets the framing error.
REQ-027 SHALL push {framing err, parity err, data} to the FIFO in the cycle after the final stop-bit sample, then return to IDLE.
REQ-028 SHALL, after a framing error, require rx high before a new START (no back-to-back false start on a break).
REQ-029 SHALL, when a push finds the FIFO full and no pop occurs that cycle, drop the new word, keep FIFO contents, and pulse overrun for 1 cycle.
REQ-030 SHALL, when a push and a pop happen in the same cycle on a full FIFO, accept both with no overrun.
REQ-031 SHALL, when a push and a pop happen in the same cycle on an empty FIFO, perform only the push; rx_valid rises the next cycle.
REQ-032 SHALL keep rx_data, rx_perr and rx_ferr stable while rx_valid is high and rx_ready is low.
REQ-033 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, using an extra pointer bit for full/empty.
REQ-034 SHALL hold rx_data at 0 while the FIFO is empty.

Reset
REQ-035 SHALL, on nrst low at a clk edge, set the state to IDLE and clear the tick counter, bit counter, shift register and FIFO pointers.
REQ-036 SHALL drive rx_valid, overrun and busy to 0, and rx_data, rx_perr and rx_ferr to 0, during and right after reset.
REQ-037 SHALL preset the synchronizer flops to 1 (idle line).
REQ-038 SHALL, on reset during a frame, discard the partial frame; the next frame is received normally once rx has been high for at least 1 bit time.

Structure
REQ-039 SHALL place the state enum, the parity-mode constants (NONE/ODD/EVEN) and a parity-function helper in the shared package uart_pkg.
REQ-040 SHALL build the FIFO as the sub-module uart_rx_fifo, parameterised by width (DATA_W+2) and FIFO_DEPTH, with a synchronous active-low reset.

Verification
REQ-041 SHALL check: defaults, frame 0x5A at OVS=16 -> rx_valid with rx_data=0x5A, perr=0, ferr=0, one cycle after the stop-bit centre.
REQ-042 SHALL check: PARITY=2, data 0x07 sent with parity bit 0 -> rx_perr=1, rx_data=0x07.
REQ-043 SHALL check: stop bit held low, data 0x00 -> rx_ferr=1; no new frame starts until rx returns high.
REQ-044 SHALL check: rx low pulse of OVS/4 ticks -> no push, busy back to 0, rx_valid stays 0.
REQ-045 SHALL check: FIFO_DEPTH=4, rx_ready=0, 5 frames 0x01..0x05 -> one overrun pulse; pops return 0x01..0x04.
REQ-046 SHALL check: nrst asserted in the middle of data bit 3 -> all outputs 0; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, parity modes and parity helper for the UART receiver
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Data is zero-extended to 9 bits so one helper covers every legal DATA_W.
   function automatic logic parity_err(input logic [8:0] data, input logic pbit, input int mode);
      logic x;
      x = (^data) ^ pbit;
      case (mode)
         PAR_ODD:  parity_err = ~x;
         PAR_EVEN: parity_err = x;
         default:  parity_err = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive word FIFO with drop-on-full and overrun pulse
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             not_empty,
   output logic             overrun
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             do_rd;
   logic             do_wr;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd     = rd_en && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_wr     = wr_en && (!full || do_rd);
   assign not_empty = !empty;
   assign rd_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= wr_en && full && !do_rd;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with parity/framing checks and receive FIFO
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int OVS        = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              baud_tick,
   input  logic              rx,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_perr,
   output logic              rx_ferr,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun,
   output logic              busy
);

   localparam logic [5:0] TICK_HALF = 6'(OVS / 2 - 1);
   localparam logic [5:0] TICK_LAST = 6'(OVS - 1);
   localparam logic [3:0] BIT_LAST  = 4'(DATA_W - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

   rx_state_t         state;
   logic              rx_s1;
   logic              rx_s2;
   logic              armed;
   logic [5:0]        tick_cnt;
   logic [3:0]        bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;
   logic              ferr;
   logic              push_pend;
   logic [DATA_W+1:0] push_word;
   logic [DATA_W+1:0] head_word;

   assign busy = (state != ST_IDLE);

   // armed is only set by a high line seen in IDLE, so a break after a bad stop bit cannot restart a frame.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= ST_IDLE;
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         armed     <= 1'b0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         ferr      <= 1'b0;
         push_pend <= 1'b0;
         push_word <= '0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         push_pend <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_s2) begin
                  armed <= 1'b1;
               end else if (baud_tick && armed) begin
                  armed    <= 1'b0;
                  tick_cnt <= '0;
                  state    <= ST_START;
               end
            end
            ST_START: if (baud_tick) begin
               if (tick_cnt == TICK_HALF) begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rx_s2 ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            ST_DATA: if (baud_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  shreg    <= {rx_s2, shreg[DATA_W-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     ferr    <= 1'b0;
                     state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            ST_PARITY: if (baud_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  par_bit  <= rx_s2;
                  state    <= ST_STOP;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            ST_STOP: if (baud_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  ferr     <= ferr | ~rx_s2;
                  if (bit_cnt == STOP_LAST) begin
                     push_word <= {ferr | ~rx_s2, parity_err(9'(shreg), par_bit, PARITY), shreg};
                     push_pend <= 1'b1;
                     bit_cnt   <= '0;
                     state     <= ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .wr_en     (push_pend),
      .wr_data   (push_word),
      .rd_en     (rx_ready),
      .rd_data   (head_word),
      .not_empty (rx_valid),
      .overrun   (overrun)
   );

   assign {rx_ferr, rx_perr, rx_data} = head_word;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for uart_rx_os (default and even-parity instances)
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       baud_tick = 1'b0;
   logic       tdiv = 1'b0;
   logic       rx0 = 1'b1, rx1 = 1'b1;
   logic       rdy0 = 1'b1, rdy1 = 1'b1;
   logic [7:0] data0, data1;
   logic       perr0, perr1, ferr0, ferr1, val0, val1, ovr0, ovr1, busy0, busy1;
   int         errors = 0;
   int         checks = 0;
   int         ovr_cnt0 = 0;
   int         ovr_cnt1 = 0;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       f;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   uart_rx_os dut0 (
      .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .rx(rx0),
      .rx_data(data0), .rx_perr(perr0), .rx_ferr(ferr0), .rx_valid(val0),
      .rx_ready(rdy0), .overrun(ovr0), .busy(busy0)
   );

   uart_rx_os #(.PARITY(2)) dut1 (
      .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .rx(rx1),
      .rx_data(data1), .rx_perr(perr1), .rx_ferr(ferr1), .rx_valid(val1),
      .rx_ready(rdy1), .overrun(ovr1), .busy(busy1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tdiv = ~tdiv;
      baud_tick = tdiv;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: compare every word the consumer accepts.
   always @(negedge clk) begin
      exp_t e;
      if (nrst) begin
         if (val0 && rdy0) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected0: got word 0x%0h required none", data0);
            end else begin
               e = q0.pop_front();
               chk("data0", data0, e.d);
               chk("perr0", perr0, e.p);
               chk("ferr0", ferr0, e.f);
            end
         end
         if (val1 && rdy1) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected1: got word 0x%0h required none", data1);
            end else begin
               e = q1.pop_front();
               chk("data1", data1, e.d);
               chk("perr1", perr1, e.p);
               chk("ferr1", ferr1, e.f);
            end
         end
         if (ovr0) ovr_cnt0++;
         if (ovr1) ovr_cnt1++;
      end
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (!baud_tick);
      end
      @(negedge clk);
   endtask

   task automatic set_rx(input int line, input logic v);
      if (line == 0) rx0 = v;
      else rx1 = v;
   endtask

   task automatic send_bit(input int line, input logic v);
      set_rx(line, v);
      wait_ticks(16);
   endtask

   task automatic send_frame(input int line, input logic [7:0] d, input logic par_en,
                             input logic pbit, input logic stopv);
      send_bit(line, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(line, d[i]);
      if (par_en) send_bit(line, pbit);
      send_bit(line, stopv);
   endtask

   task automatic expect_word(input int line, input logic [7:0] d, input logic p, input logic f);
      exp_t e;
      e.d = d; e.p = p; e.f = f;
      if (line == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic wait_drain(input int line);
      int n;
      n = 0;
      while (((line == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++; errors++;
         $display("FAIL drain%0d: timeout with %0d words outstanding, required 0", line,
                  (line == 0) ? q0.size() : q1.size());
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, val0, 0);
      chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_ovr"}, ovr0, 0);
      chk({tag, "_data"}, data0, 0);
      chk({tag, "_perr"}, perr0, 0);
      chk({tag, "_ferr"}, ferr0, 0);
   endtask

   initial begin
      int ovr_before;
      repeat (3) @(negedge clk);
      chk_idle_outputs("in_reset");
      nrst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset");
      chk("post_reset_valid1", val1, 0);
      wait_ticks(20);

      // Plain 8N1 frames on the default instance.
      expect_word(0, 8'h5A, 1'b0, 1'b0);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      expect_word(0, 8'hA5, 1'b0, 1'b0);
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      expect_word(0, 8'hFF, 1'b0, 1'b0);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      wait_drain(0);

      // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is an error.
      expect_word(1, 8'h07, 1'b1, 1'b0);
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
      expect_word(1, 8'h07, 1'b0, 1'b0);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      expect_word(1, 8'h5A, 1'b0, 1'b0);
      send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b1);
      wait_ticks(4);
      wait_drain(1);

      // Framing error with the line left low afterwards (break).
      expect_word(0, 8'h00, 1'b0, 1'b1);
      send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_ticks(48);
      chk("break_busy", busy0, 0);
      wait_drain(0);
      set_rx(0, 1'b1);
      wait_ticks(16);
      expect_word(0, 8'h33, 1'b0, 1'b0);
      send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      wait_drain(0);

      // Start-bit glitch of OVS/4 ticks.
      set_rx(0, 1'b0);
      wait_ticks(4);
      set_rx(0, 1'b1);
      wait_ticks(2);
      chk("glitch_busy_mid", busy0, 1);
      wait_ticks(20);
      chk("glitch_busy_end", busy0, 0);
      chk("glitch_valid", val0, 0);

      // Overrun: five frames into a four-word FIFO with the consumer stalled.
      ovr_before = ovr_cnt0;
      rdy0 = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) expect_word(0, 8'(i), 1'b0, 1'b0);
         send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
      end
      wait_ticks(8);
      chk("ovr_pulses", ovr_cnt0 - ovr_before, 1);
      chk("stall_valid", val0, 1);
      chk("stall_head", data0, 8'h01);
      rdy0 = 1'b1;
      wait_drain(0);
      @(negedge clk);
      chk("drained_valid", val0, 0);

      // Reset mid-frame with a word parked in the FIFO.
      rdy0 = 1'b0;
      send_frame(0, 8'h99, 1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      chk("parked_valid", val0, 1);
      send_bit(0, 1'b0);
      send_bit(0, 1'b1);
      send_bit(0, 1'b1);
      send_bit(0, 1'b0);
      set_rx(0, 1'b0);
      wait_ticks(8);
      nrst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid_reset");
      rx0 = 1'b1;
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("after_mid_reset");
      rdy0 = 1'b1;
      wait_ticks(20);
      expect_word(0, 8'hC3, 1'b0, 1'b0);
      send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      wait_drain(0);

      chk("final_q0", q0.size(), 0);
      chk("final_q1", q1.size(), 0);
      chk("ovr1_total", ovr_cnt1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
